// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an LSB-first serializer, 8N1 by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_fifo #(
    parameter int unsigned CLK_HZ     = 27000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned AW           = $clog2(FIFO_DEPTH);
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [7:0]    head;
    logic          push;
    logic          pop;

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    // Extra pointer MSB distinguishes full from empty when the index bits match
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign push  = wr_en && !full;

    assign busy    = (state != ST_IDLE);
    assign bit_end = (baud_cnt == BAUD_LAST);

    // Pop at frame start: from IDLE, or at the last stop-bit cycle for gapless frames
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == ST_IDLE) begin
                pop = 1'b1;
            end else if (state == ST_STOP && bit_end) begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            shift <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (pop) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
        end else if (state == ST_DATA && bit_end) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    // tx is registered from the next-state decision so it changes with the state
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (pop) begin
                        state <= ST_START;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            tx    <= parity_bit;
`else
                            state <= ST_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            state <= ST_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    baud_cnt <= '0;
                    tx       <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based line model (16 clocks/bit, depth 4).
// Honours UART_TX_PARITY_EN to expect 8E1 framing.
module tb_uart_tx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk     = 1'b0;
    logic       rst_i   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, busy, overflow, tx;

    uart_tx_fifo #(
        .CLK_HZ     (16),
        .BAUD       (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_i    (rst_i),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .busy     (busy),
        .overflow (overflow),
        .tx       (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int busy_cnt = 0;

    // Model: queued bytes, plus the per-cycle line samples of the frame in flight
    logic [7:0] m_fifo[$];
    logic       m_line[$];
    logic       m_ovf  = 1'b0;
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic append_frame(input logic [7:0] b);
        logic [FRAME_BITS-1:0] bits;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bits[i+1] = b[i];
        end
`ifdef UART_TX_PARITY_EN
        bits[9] = ^b;
`endif
        for (int i = 0; i < FRAME_BITS; i++) begin
            for (int c = 0; c < CPB; c++) begin
                m_line.push_back(bits[i]);
            end
        end
    endtask

    task automatic model_edge(input logic we, input logic [7:0] d);
        logic do_pop;
        logic do_push;
        do_pop  = (m_line.size() == 0) && (m_fifo.size() != 0);
        do_push = we && (m_fifo.size() < DEPTH);
        if (we && !do_push) begin
            m_ovf = 1'b1;
        end
        if (do_pop) begin
            append_frame(m_fifo.pop_front());
        end
        if (do_push) begin
            m_fifo.push_back(d);
        end
        if (m_line.size() != 0) begin
            m_tx   = m_line.pop_front();
            m_busy = 1'b1;
        end else begin
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end
    endtask

    task automatic step(input logic we, input logic [7:0] d);
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        model_edge(we, d);
        #1;
        check("tx", 32'(tx), 32'(m_tx));
        check("busy", 32'(busy), 32'(m_busy));
        check("full", 32'(full), (m_fifo.size() == DEPTH) ? 32'd1 : 32'd0);
        check("empty", 32'(empty), (m_fifo.size() == 0) ? 32'd1 : 32'd0);
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (busy) begin
            busy_cnt++;
        end
        wr_en = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int g;
        g = 0;
        while ((busy || !empty) && g < max_cyc) begin
            step(1'b0, 8'h00);
            g++;
        end
        check("drain_timeout", (busy || !empty) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Reset asserted away from the clock edge; outputs must react before any edge
    task automatic pulse_reset();
        rst_i = 1'b1;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        m_fifo.delete();
        m_line.delete();
        m_ovf  = 1'b0;
        m_tx   = 1'b1;
        m_busy = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic single_byte(input logic [7:0] b);
        busy_cnt = 0;
        step(1'b1, b);
        check("lat_pre", 32'(tx), 32'd1);
        step(1'b0, 8'h00);
        check("lat_fall", 32'(tx), 32'd0);
        drain(2 * FRAME_CYC);
        check("single_len", busy_cnt, FRAME_CYC);
    endtask

    initial begin
        int burst;
        #2;
        pulse_reset();
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        single_byte(8'h55);
        single_byte(8'h07);

        busy_cnt = 0;
        step(1'b1, 8'h41);
        step(1'b1, 8'h42);
        step(1'b1, 8'h43);
        drain(4 * FRAME_CYC);
        check("b2b_len", busy_cnt, 3 * FRAME_CYC);

        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'($urandom));
            if (i == 4) begin
                check("ovf_full", 32'(full), 32'd1);
            end
        end
        check("ovf_set", 32'(overflow), 32'd1);
        drain(7 * FRAME_CYC);
        check("ovf_frames", busy_cnt, 5 * FRAME_CYC);
        check("ovf_sticky", 32'(overflow), 32'd1);

        step(1'b1, 8'h00);
        for (int i = 0; i < 1 + 4 * CPB + 8; i++) begin
            step(1'b0, 8'h00);
        end
        pulse_reset();
        busy_cnt = 0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            step(1'b0, 8'h00);
        end
        check("post_rst_frames", busy_cnt, 0);

        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if (burst == 0 && $urandom_range(0, 199) == 0) begin
                burst = int'($urandom_range(1, 7));
            end
            if (burst > 0) begin
                burst--;
                step(1'b1, 8'($urandom));
            end else begin
                step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, 8'($urandom));
            end
        end
        drain(8 * FRAME_CYC);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter that sits directly downstream of the core's byte-output path and drives the board `TXD` pin. The core pushes bytes through a single-cycle write strobe into a small synchronous FIFO. A bit-timing state machine pops the bytes and serializes each one LSB-first with one start bit and one stop bit. Back-to-back frames are sent with no idle gap, so software print loops run at full line rate without stalling on every byte.

## Interface
- `CLK_HZ`, 27000000, input clock frequency in Hz.
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division, must be ≥ 2).
- `FIFO_DEPTH`, 16, byte slots; power of two, ≥ 2.

- `clk`  in  1  system clock; all logic is rising-edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  push strobe; sampled each rising edge.
- `wr_data`  in  8  byte to push; valid when `wr_en`=1.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `busy`  out  1  serializer is not IDLE.
- `overflow`  out  1  sticky flag: a write was attempted while `full`=1.
- `tx`  out  1  serial line; idle high; registered.

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `overflow`=0, FIFO pointers 0, FSM=IDLE, bit/baud counters 0.
- Push: `wr_en`=1 and `full`=0 at an edge stores `wr_data` at the write pointer. `wr_en`=1 with `full`=1 drops the byte and sets `overflow`. `overflow` clears only on reset.
- Occupancy uses pointers of width log2(FIFO_DEPTH)+1. Wrap-around is natural. `full`/`empty` are registered-pointer compares.
- Simultaneous push and pop in one cycle are both performed. With `full`=1, the push is still rejected even if a pop occurs in the same cycle, because `full` is sampled before the edge.
- FSM states:
  - IDLE: `tx`=1. If `empty`=0: load the head byte into the shift register, pop it, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for `CLKS_PER_BIT` cycles per bit. Shift right after each bit. After bit 7, go to PARITY if compiled in, else STOP.
  - PARITY (optional): `tx`=^byte for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. At the end: if `empty`=0, load and pop the next byte and go directly to START; else go to IDLE.
- Buffering: a popped byte leaves the FIFO at frame start. Total capacity is `FIFO_DEPTH` queued plus 1 in flight.
- `busy`=1 in every state except IDLE.

## Timing
- A write at edge N into an empty FIFO with the FSM in IDLE gives `empty`=0 after N. The FSM pops at N+1, and `tx` falls after edge N+1 (one-cycle latency).
- Every bit period is exactly `CLKS_PER_BIT` cycles. The baud counter reloads at each bit boundary and is never free-running across frames.
- 8N1 frame = 10·`CLKS_PER_BIT` cycles; 11·`CLKS_PER_BIT` with parity.
- Back-to-back: the next start bit begins on the cycle immediately after the last stop-bit cycle, with zero idle cycles.
- Reset mid-frame: `tx` returns to 1 asynchronously. The FIFO contents are discarded. The partial frame is not resumed.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in and an even-parity bit (XOR of the 8 data bits) is sent between bit 7 and the stop bit. Frame is 8E1.
- Undefined: no PARITY state and no parity logic. Frame is 8N1.

## Test plan
- Bench uses `CLK_HZ`=16, `BAUD`=1 (16 clocks/bit) and `FIFO_DEPTH`=4.
- Single byte: write 0x55 while idle. `tx` falls one cycle later, then the line carries 0,1,0,1,0,1,0,1,0,1 in 16-cycle bits. `busy` drops and `tx`=1 after 160 cycles.
- Back-to-back: write 0x41, 0x42, 0x43 on consecutive cycles. Expect three frames totalling 480 cycles from the first start edge with no high gap between the stop and start bits. `empty`=1 after the third pop.
- Overflow: write 6 bytes on consecutive cycles from idle. The first byte is popped at cycle 1, leaving 4 queued, so `full`=1. The 6th write is dropped and `overflow`=1. Exactly 5 frames are emitted, and `overflow` stays 1 afterwards.
- Reset mid-frame: assert `rst_i` for 1 cycle during bit 3 of 0x00. `tx`=1 immediately and `empty`=1. No further frames are sent and `overflow`=0.
- Parity build (`UART_TX_PARITY_EN`): write 0x07. Data bits are 1,1,1,0,0,0,0,0, then parity 1, then stop. The frame is 176 cycles.
